aligner_sched: RTL

- Sequencer sitting between the compressor's variable-length chunk stream and the 256-bit word aligner.
- Accepts byte-granular chunks on a valid/ready handshake and drives the aligner's write enable, data and length.
- Inserts drain writes when the aligner reports overflow, and inserts a zero-pad flush write at end of stream.
- Captures aligned words into a one-entry output buffer with valid/ready backpressure, marks the final word and counts words.

---
 rtl/aligner_pkg.sv | 12 +
 rtl/aligner_out_buf.sv | 32 +++
 rtl/aligner_sched.sv | 133 +++++++++++++
 3 files changed

// File: rtl/aligner_pkg.sv
// Shared widths and FSM encoding for the chunk-to-aligner sequencer.
package aligner_pkg;
  localparam int DATA_IN_WIDTH   = 272;
  localparam int DATA_OUT_WIDTH  = 256;
  localparam int LEN_WIDTH       = 8;
  localparam int CNT_WIDTH       = 32;
  localparam int MAX_CHUNK_BYTES = DATA_IN_WIDTH / 8;
  localparam int WORD_BYTES      = DATA_OUT_WIDTH / 8;
  localparam int REM_WIDTH       = 9;

  typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;
endpackage

// File: rtl/aligner_out_buf.sv
// One-entry output register with last flag and wrapping word counter; captures in 1 cycle.
// Backpressure: holds data/last while out_valid & !out_ready; caller must only capture when slot is free.
module aligner_out_buf
  import aligner_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cap,
  input  logic                      mark,
  input  logic [DATA_OUT_WIDTH-1:0] cap_data,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DATA_OUT_WIDTH-1:0] out_data,
  output logic                      out_last,
  output logic [CNT_WIDTH-1:0]      word_cnt
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      word_cnt  <= '0;
    end else if (cap) begin
      out_valid <= 1'b1;
      out_data  <= cap_data;
      out_last  <= mark;
      word_cnt  <= word_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/aligner_sched.sv
// Sequences byte chunks into the word aligner, inserting drain and zero-pad flush writes; word out 1 cycle after write.
// Backpressure: no aligner write (and in_ready low) unless the output slot is free, so no aligned word is lost.
module aligner_sched
  import aligner_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_IN_WIDTH-1:0]  in_data,
  input  logic [LEN_WIDTH-1:0]      in_len,
  input  logic                      in_last,
  output logic                      al_wrt_en,
  output logic [DATA_IN_WIDTH-1:0]  al_data,
  output logic [LEN_WIDTH-1:0]      al_len,
  input  logic [DATA_OUT_WIDTH-1:0] al_data_out,
  input  logic                      al_valid,
  input  logic                      al_stall,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_OUT_WIDTH-1:0] out_data,
  output logic                      out_last,
  output logic [CNT_WIDTH-1:0]      word_cnt,
  output logic                      err_len
);
  state_t               state, state_nxt;
  logic [REM_WIDTH-1:0] rem, rem_nxt, rem_after;
  logic [9:0]           merged;
  logic [LEN_WIDTH-1:0] pad_len;
  logic                 pend_last, pend_last_nxt;
  logic                 slot_free, len_ok, accept, mark, cap;

  assign slot_free = !out_valid || out_ready;
  assign len_ok    = in_len <= LEN_WIDTH'(MAX_CHUNK_BYTES);
  assign accept    = in_valid && in_ready;
  assign pad_len   = LEN_WIDTH'(WORD_BYTES) - {3'b000, rem[7:3]};

  // rem tracks bits held inside the aligner after the current write
  assign merged    = {1'b0, rem} + {al_len[6:0], 3'b000};
  assign rem_nxt   = (merged >= 10'd256) ? REM_WIDTH'(merged - 10'd256) : REM_WIDTH'(merged);
  assign rem_after = al_wrt_en ? rem_nxt : rem;
  assign cap       = al_wrt_en && al_valid;

  // Write-side outputs: kept free of al_stall/al_valid to avoid a loop through the aligner
  always_comb begin
    in_ready  = 1'b0;
    al_wrt_en = 1'b0;
    al_data   = '0;
    al_len    = '0;
    if (reset) begin
      case (state)
        RUN: begin
          in_ready  = slot_free;
          al_data   = in_data;
          al_len    = in_len;
          al_wrt_en = in_valid && slot_free && len_ok;
        end
        DRAIN: al_wrt_en = slot_free;
        FLUSH: begin
          al_wrt_en = slot_free;
          al_len    = pad_len;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    pend_last_nxt = pend_last;
    mark          = 1'b0;
    case (state)
      RUN: begin
        if (accept) begin
          if (al_wrt_en && al_stall) begin
            state_nxt     = DRAIN;
            pend_last_nxt = in_last;
          end else if (in_last && rem_after != '0) begin
            state_nxt = FLUSH;
          end else begin
            mark = in_last;
          end
        end
      end
      DRAIN: begin
        if (slot_free) begin
          if (pend_last && rem_nxt != '0) begin
            state_nxt = FLUSH;
          end else begin
            mark          = pend_last;
            pend_last_nxt = 1'b0;
            state_nxt     = RUN;
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          mark          = 1'b1;
          pend_last_nxt = 1'b0;
          state_nxt     = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      rem       <= '0;
      pend_last <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rem       <= rem_after;
      pend_last <= pend_last_nxt;
      if (accept && !len_ok) err_len <= 1'b1;
    end
  end

  aligner_out_buf u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .cap       (cap),
    .mark      (mark),
    .cap_data  (al_data_out),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .word_cnt  (word_cnt)
  );
endmodule
